rle_frame_encoder: RTL

//  Streaming run-length encoder: the writer-side counterpart of the RLE video decoder.

---
 rtl/rle_frame_if.sv | 33 +++
 rtl/rle_frame_encoder.sv | 113 +++++++++++
 2 files changed

// File: rtl/rle_frame_if.sv
// ============================================================================
// rle_frame_if : pixel-in / run-word-out handshake bundle for rle_frame_encoder
// Rev 1.0
// ============================================================================
`default_nettype none

interface rle_frame_if #(
  parameter int COLOUR_BITS = 6,
  parameter int RUN_BITS    = 10
);
  logic                            pix_valid;
  logic                            pix_ready;
  logic [COLOUR_BITS-1:0]          pix_colour;
  logic                            pix_eol;
  logic                            pix_eof;
  logic                            word_valid;
  logic                            word_ready;
  logic [RUN_BITS+COLOUR_BITS-1:0] word_data;
  logic                            word_last;
  logic                            run_active;

  modport master (
    output pix_valid, pix_colour, pix_eol, pix_eof, word_ready,
    input  pix_ready, word_valid, word_data, word_last, run_active
  );

  modport slave (
    input  pix_valid, pix_colour, pix_eol, pix_eof, word_ready,
    output pix_ready, word_valid, word_data, word_last, run_active
  );
endinterface

`default_nettype wire

// File: rtl/rle_frame_encoder.sv
// ============================================================================
// rle_frame_encoder : streaming run-length encoder, {run_len_m1, colour} words.
// Optional RLE_ENC_LINE_SPLIT_EN: close runs at every end of line.
// Rev 1.0
// ============================================================================
`default_nettype none

module rle_frame_encoder #(
  parameter int COLOUR_BITS = 6,
  parameter int RUN_BITS    = 10
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  rle_frame_if.slave  bus
);

  localparam int                WORD_BITS = RUN_BITS + COLOUR_BITS;
  localparam logic [RUN_BITS-1:0] LEN_MAX = '1;

  logic                   run_open, run_open_n;
  logic [COLOUR_BITS-1:0] cur_colour, colour_n;
  logic [RUN_BITS-1:0]    cur_len, len_n;
  logic [WORD_BITS-1:0]   fifo_data   [2];
  logic                   fifo_last   [2];
  logic [WORD_BITS-1:0]   fifo_data_n [2];
  logic                   fifo_last_n [2];
  logic [1:0]             cnt, cnt_n, slot;
  logic                   pop, ready, accept, close_run, push_old, push_new;

  assign pop    = (cnt != 2'd0) && bus.word_ready;
  assign ready  = (cnt == 2'd0) || ((cnt == 2'd1) && bus.word_ready);
  assign accept = bus.pix_valid && ready;

`ifdef RLE_ENC_LINE_SPLIT_EN
  assign close_run = bus.pix_eof || bus.pix_eol;
`else
  assign close_run = bus.pix_eof;
`endif

  always_comb begin : run_next
    run_open_n = run_open;
    colour_n   = cur_colour;
    len_n      = cur_len;
    push_old   = 1'b0;
    push_new   = 1'b0;
    if (accept) begin
      if (run_open && (bus.pix_colour == cur_colour) && (cur_len != LEN_MAX)) begin
        len_n = cur_len + RUN_BITS'(1);
      end else begin
        push_old = run_open;
        colour_n = bus.pix_colour;
        len_n    = '0;
      end
      run_open_n = 1'b1;
      if (close_run) begin
        push_new   = 1'b1;
        run_open_n = 1'b0;
      end
    end
  end

  // Ready rule ensures slot never reaches 2 while a push is pending.
  always_comb begin : fifo_next
    fifo_data_n = fifo_data;
    fifo_last_n = fifo_last;
    slot        = cnt;
    if (pop) begin
      fifo_data_n[0] = fifo_data[1];
      fifo_last_n[0] = fifo_last[1];
      slot           = cnt - 2'd1;
    end
    if (push_old) begin
      fifo_data_n[slot[0]] = {cur_len, cur_colour};
      fifo_last_n[slot[0]] = 1'b0;
      slot                 = slot + 2'd1;
    end
    if (push_new) begin
      fifo_data_n[slot[0]] = {len_n, colour_n};
      fifo_last_n[slot[0]] = bus.pix_eof;
      slot                 = slot + 2'd1;
    end
    cnt_n = slot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_open   <= 1'b0;
      cur_colour <= '0;
      cur_len    <= '0;
      cnt        <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      run_open   <= run_open_n;
      cur_colour <= colour_n;
      cur_len    <= len_n;
      cnt        <= cnt_n;
      fifo_data  <= fifo_data_n;
      fifo_last  <= fifo_last_n;
    end
  end

  assign bus.pix_ready  = ready;
  assign bus.word_valid = (cnt != 2'd0);
  assign bus.word_data  = fifo_data[0];
  assign bus.word_last  = fifo_last[0];
  assign bus.run_active = run_open;

endmodule

`default_nettype wire
